// File: rtl/aes_seq_pkg.sv
// Shared types and helpers for the iterative AES-128 round sequencer.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT,
        WAIT,
        UPDATE,
        DONE
    } seq_state_t;

    localparam int         NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/rcon_gen.sv
// Round-constant register for the key expansion: clear to 01, advance by xtime.
module rcon_gen
    import aes_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       adv,
    output logic [7:0] rcon
);

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcon <= RCON_INIT;
        end else if (clr) begin
            rcon <= RCON_INIT;
        end else if (adv) begin
            rcon <= xtime(rcon);
        end
    end

endmodule

// File: rtl/aes_round_seq.sv
// Control sequencer for a shared one-round AES-128 datapath: initial
// AddRoundKey then rounds 1..NUM_ROUNDS, each padded by SBOX_LAT wait cycles.
module aes_round_seq
    import aes_seq_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    output logic       init_sel,
    output logic       key_init,
    output logic       state_en,
    output logic       key_en,
    output logic       mix_bypass,
    output logic [3:0] round,
    output logic [7:0] rcon,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_ROUND  = 4'(NUM_ROUNDS);
    localparam int         WAIT_LAST_I = (SBOX_LAT > 0) ? SBOX_LAT - 1 : 0;
    localparam logic [1:0] WAIT_LAST   = WAIT_LAST_I[1:0];
    localparam bit         NO_WAIT     = (SBOX_LAT == 0);

    seq_state_t state, state_nxt;
    logic [1:0] wait_cnt, wait_cnt_nxt;
    logic [3:0] round_nxt;
    logic       rcon_clr, rcon_adv;
    logic       last_round;

    assign last_round = (round == LAST_ROUND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            round    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            round    <= round_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        case (state)
            IDLE:    if (load) state_nxt = LOAD;
            LOAD:    if (!load) state_nxt = INIT;
            INIT: begin
                if (load) state_nxt = LOAD;
                else      state_nxt = NO_WAIT ? UPDATE : WAIT;
            end
            WAIT: begin
                if (load) begin
                    state_nxt = LOAD;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = UPDATE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            UPDATE: begin
                if (load)            state_nxt = LOAD;
                else if (last_round) state_nxt = DONE;
                else                 state_nxt = NO_WAIT ? UPDATE : WAIT;
            end
            DONE:    if (load) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Round number and rcon move together; any return to LOAD discards progress.
    always_comb begin
        round_nxt = round;
        if (state_nxt == LOAD) begin
            round_nxt = '0;
        end else if (state == INIT) begin
            round_nxt = 4'd1;
        end else if (state == UPDATE && !last_round) begin
            round_nxt = round + 4'd1;
        end
    end

    assign rcon_clr = (state_nxt == LOAD) || (state == INIT);
    assign rcon_adv = (state == UPDATE) && !last_round;

    rcon_gen u_rcon_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (rcon_clr),
        .adv   (rcon_adv),
        .rcon  (rcon)
    );

    // Moore outputs decoded from the registered state only.
    always_comb begin
        init_sel   = 1'b0;
        key_init   = 1'b0;
        state_en   = 1'b0;
        key_en     = 1'b0;
        mix_bypass = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            INIT: begin
                init_sel = 1'b1;
                key_init = 1'b1;
                state_en = 1'b1;
                key_en   = 1'b1;
                busy     = 1'b1;
            end
            WAIT: begin
                busy       = 1'b1;
                mix_bypass = last_round;
            end
            UPDATE: begin
                state_en   = 1'b1;
                key_en     = 1'b1;
                busy       = 1'b1;
                mix_bypass = last_round;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: two instances (SBOX_LAT 0 and 1) against a cycle-count
// model, plus a behavioural AES datapath driven by the SBOX_LAT=1 controls.
module tb_aes_round_seq;

    logic clk = 1'b0;
    logic reset;
    logic load;

    always #5 clk = ~clk;

    logic       is0, ki0, se0, ke0, mb0, b0, d0;
    logic [3:0] r0;
    logic [7:0] rc0;
    logic       is1, ki1, se1, ke1, mb1, b1, d1;
    logic [3:0] r1;
    logic [7:0] rc1;

    aes_round_seq #(.SBOX_LAT(0)) u_lat0 (
        .clk(clk), .reset(reset), .load(load),
        .init_sel(is0), .key_init(ki0), .state_en(se0), .key_en(ke0),
        .mix_bypass(mb0), .round(r0), .rcon(rc0), .busy(b0), .done(d0)
    );

    aes_round_seq #(.SBOX_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .load(load),
        .init_sel(is1), .key_init(ki1), .state_en(se1), .key_en(ke1),
        .mix_bypass(mb1), .round(r1), .rcon(rc1), .busy(b1), .done(d1)
    );

    logic [18:0] obs [2];
    always_comb begin
        obs[0] = {is0, ki0, se0, ke0, mb0, r0, rc0, b0, d0};
        obs[1] = {is1, ki1, se1, ke1, mb1, r1, rc1, b1, d1};
    end

    int checks = 0;
    int errors = 0;

    // ---------------- reference model of the sequencer ----------------
    localparam int M_IDLE = 0, M_LOADING = 1, M_RUN = 2, M_FIN = 3;
    int m_st [2];
    int m_t  [2];   // cycles since the INIT cycle
    logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [18:0] model_out(input int l);
        int p, rnd;
        logic first, upd;
        logic [7:0] rc;
        logic [18:0] res;
        p   = l + 1;
        res = {5'b0, 4'd0, 8'h01, 2'b00};
        if (m_st[l] == M_RUN) begin
            first = (m_t[l] == 0);
            rnd   = first ? 0 : (m_t[l] + l) / p;
            upd   = !first && (m_t[l] % p == 0);
            rc    = (rnd == 0) ? 8'h01 : rc_tab[rnd-1];
            res   = {first, first, first | upd, first | upd, (rnd == 10),
                     4'(rnd), rc, 1'b1, 1'b0};
        end else if (m_st[l] == M_FIN) begin
            res = {5'b0, 4'd10, 8'h36, 1'b0, 1'b1};
        end
        return res;
    endfunction

    task automatic model_step(input int l, input logic ld);
        case (m_st[l])
            M_IDLE:    if (ld) m_st[l] = M_LOADING;
            M_LOADING: if (!ld) begin m_st[l] = M_RUN; m_t[l] = 0; end
            M_RUN: begin
                if (ld)                          m_st[l] = M_LOADING;
                else if (m_t[l] == 10 * (l + 1)) m_st[l] = M_FIN;
                else                             m_t[l]  = m_t[l] + 1;
            end
            default:   if (ld) m_st[l] = M_LOADING;
        endcase
    endtask

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            m_st[l] = M_IDLE;
            m_t[l]  = 0;
        end
    endtask

    // ---------------- behavioural AES datapath ----------------
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [7:0]   sbox_t [256];
    logic [127:0] dp_state, dp_key;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, a;
        for (int v = 0; v < 256; v++) begin
            a   = 8'(v);
            inv = 8'h00;
            if (v != 0)
                for (int w = 1; w < 256; w++)
                    if (gmul(a, 8'(w)) == 8'h01) inv = 8'(w);
            sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
             ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic skip_mix);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] m [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            if (skip_mix) begin
                for (int r = 0; r < 4; r++) m[r+4*c] = b[r+4*c];
            end else begin
                m[4*c]   = gmul(b[4*c], 8'h02) ^ gmul(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3];
                m[4*c+1] = b[4*c] ^ gmul(b[4*c+1], 8'h02) ^ gmul(b[4*c+2], 8'h03) ^ b[4*c+3];
                m[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(b[4*c+2], 8'h02) ^ gmul(b[4*c+3], 8'h03);
                m[4*c+3] = gmul(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(b[4*c+3], 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
        return o ^ rk;
    endfunction

    // Applies what the next edge does to the datapath, from the controls now showing.
    task automatic dp_step();
        logic [127:0] nk;
        nk = ki1 ? KEY : expand_key(dp_key, rc1);
        if (se1) dp_state = is1 ? (PT ^ KEY) : aes_round(dp_state, nk, mb1);
        if (ke1) dp_key = nk;
    endtask

    // ---------------- checking ----------------
    bit prev_done [2];
    int se_cnt [2];
    int ke_cnt [2];

    task automatic check_outputs();
        logic [18:0] exp_v;
        for (int l = 0; l < 2; l++) begin
            exp_v = model_out(l);
            checks++;
            assert (obs[l] === exp_v) else begin
                errors++;
                $error("FAIL outputs_lat%0d at %0t: observed=%h expected=%h", l, $time, obs[l], exp_v);
            end
            if (obs[l][18]) begin
                se_cnt[l] = 0;
                ke_cnt[l] = 0;
            end
            if (obs[l][16]) se_cnt[l]++;
            if (obs[l][15]) ke_cnt[l]++;
            if (obs[l][0] && !prev_done[l]) begin
                checks++;
                assert ({se_cnt[l], ke_cnt[l]} === {32'd11, 32'd11}) else begin
                    errors++;
                    $error("FAIL enable_count_lat%0d: observed state_en=%0d key_en=%0d expected 11/11",
                           l, se_cnt[l], ke_cnt[l]);
                end
                if (l == 1) begin
                    checks++;
                    assert (dp_state === CT) else begin
                        errors++;
                        $error("FAIL ciphertext: observed=%h expected=%h", dp_state, CT);
                    end
                end
            end
            prev_done[l] = obs[l][0];
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic ld);
        dp_step();
        load = ld;
        @(posedge clk);
        if (!reset) begin
            model_step(0, ld);
            model_step(1, ld);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        int hi, lo;
        build_sbox();
        for (int l = 0; l < 2; l++) begin
            prev_done[l] = 1'b0;
            se_cnt[l]    = 0;
            ke_cnt[l]    = 0;
        end
        reset = 1'b1;
        load  = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        check_outputs();

        // Normal encryption for both latencies; done holds afterwards.
        repeat (3) cycle(1'b1);
        repeat (30) cycle(1'b0);

        // Abort during round 4 of the SBOX_LAT=1 run, then a fresh run.
        repeat (3) cycle(1'b1);
        repeat (8) cycle(1'b0);
        cycle(1'b1);
        repeat (30) cycle(1'b0);

        // From DONE, load held for 50 cycles, then a normal run.
        repeat (50) cycle(1'b1);
        repeat (30) cycle(1'b0);

        // Single-cycle load pulse.
        cycle(1'b1);
        repeat (25) cycle(1'b0);

        // Reset during the round-5 UPDATE of the SBOX_LAT=1 instance.
        repeat (3) cycle(1'b1);
        repeat (11) cycle(1'b0);
        do_reset();
        repeat (4) cycle(1'b0);
        repeat (2) cycle(1'b1);
        repeat (25) cycle(1'b0);

        // Randomised load patterns with occasional asynchronous reset.
        for (int it = 0; it < 60; it++) begin
            hi = $urandom_range(1, 4);
            lo = $urandom_range(2, 28);
            for (int k = 0; k < hi; k++) cycle(1'b1);
            for (int k = 0; k < lo; k++) begin
                cycle(1'b0);
                if ($urandom_range(0, 149) == 0) do_reset();
            end
        end
        repeat (25) cycle(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
Iterative AES-128 encryption sequencer. It drives the control inputs of the shared one-round datapath: state register, round-key register, synchronous S-box, shiftrows, the mixcolumns bypass mux and addroundkey. It implements the load/done handshake with the SPI front end and steps the datapath through initial AddRoundKey plus rounds 1..10, one round per (SBOX_LAT+1) cycles. Control only: no 128-bit data passes through this block.

Parameters:
SBOX_LAT, 1, clock cycles from S-box address to valid S-box data (legal 0..3); wait cycles inserted before each round update.
NUM_ROUNDS, 10, AES-128 round count; fixed, not for override.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
load  input  1  high while the SPI front end shifts plaintext/key; the high-to-low transition starts encryption.
init_sel  output  1  selects (plaintext ^ key) as the next state-register value; otherwise the round-output path.
key_init  output  1  selects the raw input key as the next round-key value; otherwise the key-expansion output.
state_en  output  1  state-register write enable.
key_en  output  1  round-key register write enable.
mix_bypass  output  1  skip mixcolumns; high for round 10 only.
round  output  4  current round number, 0..10.
rcon  output  8  round constant for the key expansion of the current round.
busy  output  1  high from INIT through the last UPDATE.
done  output  1  ciphertext valid; held until the next load.

Behaviour:
- Reset, asynchronous: FSM=IDLE, round=0, rcon=8'h01, wait counter=0. All enables, selects, busy and done are 0.
- States:
  - IDLE: load=1 -> LOAD.
  - LOAD: outputs idle; load=0 -> INIT.
  - INIT (1 cycle): init_sel=key_init=state_en=key_en=1, busy=1. Next state is WAIT with round=1, or UPDATE if SBOX_LAT=0.
  - WAIT (SBOX_LAT cycles, counted by the wait counter): no enables; lets S-box data settle.
  - UPDATE (1 cycle): state_en=key_en=1, init_sel=key_init=0. If round<10: round+1, rcon<=xtime(rcon), counter cleared, -> WAIT/UPDATE. If round=10 -> DONE.
  - DONE: done=1, busy=0, round holds 10. load=1 -> LOAD with done=0.
- mix_bypass = (round==10) in WAIT and UPDATE; 0 elsewhere.
- xtime: shift left 1; if the old bit7 was 1, XOR 8'h1b. Sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1b,36. rcon is reloaded to 8'h01 in INIT.
- round and rcon are registered and change only on UPDATE edges. Consumers see a stable value for the whole round.
- Latency: the first edge sampling load=0 in LOAD enters INIT. done rises 1+10*(SBOX_LAT+1) edges later: 21 for SBOX_LAT=1, 11 for SBOX_LAT=0.
- Enable counts per encryption: state_en and key_en are each high for exactly 11 cycles (1 INIT + 10 UPDATE).
- load=1 in any state other than IDLE/LOAD (abort): next state is LOAD. round=0, rcon=8'h01, done=0, busy=0, no enables. The partial result is discarded.
- load held high indefinitely: stay in LOAD.
- load pulsing high for 1 cycle: LOAD, then INIT on the next edge.
- reset during any state: immediate return to the reset values, regardless of load.
- Outputs are Moore, decoded from state only. There are no combinational paths from load to any output.

Decomposition:
- Package aes_seq_pkg holds:
  - state enum {IDLE, LOAD, INIT, WAIT, UPDATE, DONE}
  - NUM_ROUNDS=10
  - RCON_INIT=8'h01
  - function xtime(input [7:0]) -> [7:0]
- One sub-module, rcon_gen: 8-bit rcon register with sync clear-to-01 and advance enable, using xtime.
- FSM, round counter and wait counter stay in aes_round_seq.

Test Plan:
1. Reset asserted mid-UPDATE (round=5) -> same-cycle round=0, rcon=01, all enables/done=0; after release, state is IDLE.
2. load high 3 cycles then low, SBOX_LAT=1 -> INIT 1 cycle; state_en pulses 11 times, every 2 cycles; rcon per round =01..80,1b,36; mix_bypass only in round 10; done rises at edge 21 and holds.
3. Same stimulus with SBOX_LAT=0 -> state_en high 11 consecutive cycles; done at edge 11.
4. load pulsed high during round 4 -> next cycle LOAD, busy=0, round=0; after load falls a full fresh encryption runs with rcon restarting at 01.
5. DONE then load high -> done drops the next cycle; load held 50 cycles -> no enables asserted; release -> normal run.
6. Datapath integration with FIPS-197 Appendix C.1 key 000102..0f, plaintext 00112233..ff -> ciphertext 69c4e0d8..c55a captured when done=1.
